trig_seq_gen: RTL and testbench

Parametrised multi-channel trigger sequencer for the trigger/timing path. After an arm, it waits a programmable period, then emits a PL1 pulse and NCH independently delayed trigger pulses inside a fixed-length sequence window. It runs one-shot or continuous, counts completed sequences, and reports busy/done. It generalises the single-channel PL1-then-trigger generator: width, channel count, pulse lengths and repeat mode are all configurable.

---
 rtl/trig_seq_pkg.sv | 15 +
 rtl/trig_seq_gen_if.sv | 41 ++++
 rtl/trig_chan_win.sv | 38 +++
 rtl/trig_seq_gen.sv | 157 +++++++++++++++
 tb/tb_trig_seq_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/trig_seq_pkg.sv
// trig_seq_pkg
// Shared definitions for the trigger sequencer: the FSM state encoding and
// the default timing-counter width.
package trig_seq_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/trig_seq_gen_if.sv
// trig_seq_gen_if
// Control, configuration and pulse bundle of the trigger sequencer.
//   ena, arm, cont          : run control (master -> sequencer)
//   period, pl1_len,
//   trig_dly, trig_len,
//   seq_len                 : timing configuration (master -> sequencer)
//   pl1, trig               : registered pulse outputs (sequencer -> master)
//   busy, seq_done,
//   seq_count               : status (sequencer -> master)
interface trig_seq_gen_if
  import trig_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NCH   = 4
);

  logic                 ena;
  logic                 arm;
  logic                 cont;
  logic [CNT_W-1:0]     period;
  logic [CNT_W-1:0]     pl1_len;
  logic [NCH*CNT_W-1:0] trig_dly;
  logic [CNT_W-1:0]     trig_len;
  logic [CNT_W-1:0]     seq_len;
  logic                 pl1;
  logic [NCH-1:0]       trig;
  logic                 busy;
  logic                 seq_done;
  logic [CNT_W-1:0]     seq_count;

  modport master (
    output ena, arm, cont, period, pl1_len, trig_dly, trig_len, seq_len,
    input  pl1, trig, busy, seq_done, seq_count
  );

  modport slave (
    input  ena, arm, cont, period, pl1_len, trig_dly, trig_len, seq_len,
    output pl1, trig, busy, seq_done, seq_count
  );

endinterface

// File: rtl/trig_chan_win.sv
// trig_chan_win
// One trigger channel: registered window compare of the FIRE phase counter.
//   clk, rst : clock, synchronous active-high reset
//   fire_i   : sequencer is in FIRE and enabled this cycle
//   f_i      : FIRE phase counter
//   dly_i    : channel delay from the first PL1 cycle
//   len_i    : pulse width, already forced to at least 1
//   pulse_o  : registered trigger pulse
module trig_chan_win #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire_i,
  input  logic [CNT_W-1:0] f_i,
  input  logic [CNT_W-1:0] dly_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             pulse_o
);

  logic [CNT_W:0] win_end;
  logic           pulse_q;

  // One extra bit so dly + len never wraps back into range.
  assign win_end = {1'b0, dly_i} + {1'b0, len_i};

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= fire_i && (f_i >= dly_i) && ({1'b0, f_i} < win_end);
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/trig_seq_gen.sv
// trig_seq_gen
// Multi-channel trigger sequencer. After an arm it waits a programmable
// period, then opens a FIRE window in which PL1 and NCH delayed trigger
// pulses are produced, then strobes seq_done and bumps seq_count. Runs
// one-shot or continuously; all outputs are registered one cycle behind
// the FSM state.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : trig_seq_gen_if slave (control, configuration, pulses, status)
module trig_seq_gen
  import trig_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NCH   = 4
) (
  input logic          clk,
  input logic          rst,
  trig_seq_gen_if.slave bus
);

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     phase_q, phase_d;
  logic                 latch;

  logic [CNT_W-1:0]     per_q;
  logic [CNT_W-1:0]     pl1_len_q;
  logic [CNT_W-1:0]     trig_len_q;
  logic [CNT_W-1:0]     seq_len_q;
  logic [NCH*CNT_W-1:0] dly_q;

  logic                 pl1_q;
  logic                 busy_q;
  logic                 seq_done_q;
  logic [CNT_W-1:0]     seq_count_q;
  logic                 fire;
  logic [NCH-1:0]       trig_w;

  // FSM state and phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic; ena low leaves the defaults, which freeze everything.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    latch   = 1'b0;
    if (bus.ena) begin
      unique case (state_q)
        IDLE: begin
          if (bus.arm) begin
            latch   = 1'b1;
            phase_d = '0;
            state_d = (bus.period == '0) ? FIRE : WAIT;
          end
        end
        WAIT: begin
          if (phase_q == per_q - CNT_W'(1)) begin
            phase_d = '0;
            state_d = FIRE;
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end
        FIRE: begin
          if (phase_q == seq_len_q - CNT_W'(1)) begin
            phase_d = '0;
            state_d = DONE;
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end
        DONE: begin
          phase_d = '0;
          if (bus.cont) begin
            // The next sequence decides WAIT vs FIRE on the freshly latched period.
            latch   = 1'b1;
            state_d = (bus.period == '0) ? FIRE : WAIT;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shadow configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      per_q      <= '0;
      pl1_len_q  <= '0;
      trig_len_q <= '0;
      seq_len_q  <= '0;
      dly_q      <= '0;
    end else if (latch) begin
      per_q      <= bus.period;
      pl1_len_q  <= at_least_one(bus.pl1_len);
      trig_len_q <= at_least_one(bus.trig_len);
      seq_len_q  <= at_least_one(bus.seq_len);
      dly_q      <= bus.trig_dly;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pl1_q       <= 1'b0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_count_q <= '0;
    end else begin
      busy_q <= (state_q != IDLE);
      if (bus.ena) begin
        pl1_q      <= (state_q == FIRE) && (phase_q < pl1_len_q);
        seq_done_q <= (state_q == DONE);
        if (state_q == DONE) begin
          seq_count_q <= seq_count_q + CNT_W'(1);
        end
      end else begin
        pl1_q      <= 1'b0;
        seq_done_q <= 1'b0;
      end
    end
  end

  assign fire = bus.ena && (state_q == FIRE);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    trig_chan_win #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .fire_i  (fire),
      .f_i     (phase_q),
      .dly_i   (dly_q[k*CNT_W +: CNT_W]),
      .len_i   (trig_len_q),
      .pulse_o (trig_w[k])
    );
  end

  assign bus.pl1       = pl1_q;
  assign bus.trig      = trig_w;
  assign bus.busy      = busy_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.seq_count = seq_count_q;

endmodule

// File: tb/tb_trig_seq_gen.sv
// tb_trig_seq_gen
// Directed bench for trig_seq_gen: one 16-bit/4-channel instance for the
// sequence, ena-gap and reset cases, one 4-bit/1-channel instance for the
// counter wrap and latched-period behaviour.
module tb_trig_seq_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  trig_seq_gen_if #(.CNT_W(16), .NCH(4)) bus16 ();
  trig_seq_gen_if #(.CNT_W(4),  .NCH(1)) bus4 ();

  trig_seq_gen #(.CNT_W(16), .NCH(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  trig_seq_gen #(.CNT_W(4), .NCH(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg16(input int per, input int p1, input int tl, input int sl,
                           input int d0, input int d1, input int d2, input int d3);
    bus16.period   = 16'(per);
    bus16.pl1_len  = 16'(p1);
    bus16.trig_len = 16'(tl);
    bus16.seq_len  = 16'(sl);
    bus16.trig_dly = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endtask

  // One-shot run on dut16 with effective lengths passed in; optional ena gap
  // covering the edges gs .. gs+gl-1 after the arm edge.
  task automatic run_oneshot(input string nm, input int per, input int p1, input int tl,
                             input int sl, input int d0, input int d1, input int d2,
                             input int d3, input int gs, input int gl, input int cnt0);
    int d[4];
    int f;
    int te;
    int ec;
    logic [3:0] et;
    logic ep, ed, eb, in_gap;
    d = '{d0, d1, d2, d3};
    bus16.arm = 1'b1;
    step();
    bus16.arm = 1'b0;
    for (int t = 1; t <= per + sl + 2 + gl; t++) begin
      in_gap = (gl > 0) && (t >= gs) && (t < gs + gl);
      bus16.ena = !in_gap;
      step();
      if (in_gap) begin
        check_eq($sformatf("%s.gap t=%0d", nm, t),
                 32'({bus16.seq_done, bus16.pl1, bus16.trig}), 32'd0);
        check_eq($sformatf("%s.gapcnt t=%0d", nm, t), 32'(bus16.seq_count), 32'(cnt0));
      end else begin
        te = ((gl > 0) && (t >= gs + gl)) ? t - gl : t;
        f  = te - (per + 1);
        ep = (f >= 0) && (f < sl) && (f < p1);
        for (int k = 0; k < 4; k++) begin
          et[k] = (f >= 0) && (f < sl) && (f >= d[k]) && (f < d[k] + tl);
        end
        ed = (te == per + sl + 1);
        eb = (te >= 1) && (te <= per + sl + 1);
        ec = cnt0 + ((te >= per + sl + 1) ? 1 : 0);
        check_eq($sformatf("%s.out t=%0d", nm, t),
                 32'({bus16.busy, bus16.seq_done, bus16.pl1, bus16.trig}),
                 32'({eb, ed, ep, et}));
        check_eq($sformatf("%s.cnt t=%0d", nm, t), 32'(bus16.seq_count), 32'(ec));
      end
    end
    bus16.ena = 1'b1;
  endtask

  initial begin
    int   nd;
    int   chg;
    int   dt[20];
    logic plog[0:80];

    rst = 1'b1;
    bus16.ena = 1'b1; bus16.arm = 1'b0; bus16.cont = 1'b0;
    set_cfg16(0, 0, 0, 0, 0, 0, 0, 0);
    bus4.ena = 1'b1; bus4.arm = 1'b0; bus4.cont = 1'b0;
    bus4.period = 4'd0; bus4.pl1_len = 4'd0; bus4.trig_len = 4'd0;
    bus4.seq_len = 4'd0; bus4.trig_dly = 4'd0;
    step();
    step();
    check_eq("rst.pl1",   32'(bus16.pl1),       32'd0);
    check_eq("rst.trig",  32'(bus16.trig),      32'd0);
    check_eq("rst.busy",  32'(bus16.busy),      32'd0);
    check_eq("rst.done",  32'(bus16.seq_done),  32'd0);
    check_eq("rst.cnt",   32'(bus16.seq_count), 32'd0);
    check_eq("rst.cnt4",  32'(bus4.seq_count),  32'd0);
    rst = 1'b0;
    step();

    // Basic one-shot; channel 3 lies past the window.
    set_cfg16(5, 3, 2, 12, 0, 2, 10, 12);
    run_oneshot("t1", 5, 3, 2, 12, 0, 2, 10, 12, 0, 0, 0);

    // Zero lengths and period behave as minimum values.
    set_cfg16(0, 0, 0, 0, 0, 0, 0, 0);
    run_oneshot("t2", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);

    // Continuous mode, cont dropped after the third seq_done.
    set_cfg16(4, 2, 1, 8, 0, 1, 3, 7);
    bus16.cont = 1'b1;
    bus16.arm  = 1'b1;
    step();
    bus16.arm = 1'b0;
    nd = 0;
    plog[0] = 1'b0;
    for (int t = 1; t <= 80; t++) begin
      step();
      plog[t] = bus16.pl1;
      if (bus16.seq_done) begin
        if (nd < 20) dt[nd] = t;
        nd++;
        if (nd == 3) bus16.cont = 1'b0;
      end
    end
    check_eq("t3.ndone", 32'(nd), 32'd4);
    check_eq("t3.first", 32'(dt[0]), 32'd13);
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("t3.gap%0d", i), 32'(dt[i] - dt[i-1]), 32'd13);
    end
    check_eq("t3.pl1pre",  32'(plog[4]), 32'd0);
    check_eq("t3.pl1on",   32'(plog[5]), 32'd1);
    check_eq("t3.pl1off",  32'(plog[7]), 32'd0);
    check_eq("t3.pl1pre2", 32'(plog[dt[0] + 4]), 32'd0);
    check_eq("t3.pl1on2",  32'(plog[dt[0] + 5]), 32'd1);
    check_eq("t3.busy",    32'(bus16.busy), 32'd0);
    check_eq("t3.cnt",     32'(bus16.seq_count), 32'd6);

    // ena low for 7 edges while the FIRE counter sits at 2.
    set_cfg16(5, 3, 2, 12, 0, 2, 10, 12);
    run_oneshot("t4", 5, 3, 2, 12, 0, 2, 10, 12, 8, 7, 6);

    // Reset in the middle of FIRE, then a clean sequence.
    bus16.arm = 1'b1;
    step();
    bus16.arm = 1'b0;
    for (int t = 1; t <= 7; t++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5.pl1",  32'(bus16.pl1),       32'd0);
    check_eq("t5.trig", 32'(bus16.trig),      32'd0);
    check_eq("t5.busy", 32'(bus16.busy),      32'd0);
    check_eq("t5.done", 32'(bus16.seq_done),  32'd0);
    check_eq("t5.cnt",  32'(bus16.seq_count), 32'd0);
    run_oneshot("t5r", 5, 3, 2, 12, 0, 2, 10, 12, 0, 0, 0);

    // 4-bit counter wrap over 16 continuous sequences; period change in FIRE.
    bus4.period = 4'd1; bus4.pl1_len = 4'd1; bus4.trig_len = 4'd1;
    bus4.seq_len = 4'd2; bus4.trig_dly = 4'd0;
    bus4.cont = 1'b1;
    bus4.arm  = 1'b1;
    step();
    bus4.arm = 1'b0;
    nd  = 0;
    chg = -1;
    for (int t = 1; t <= 120; t++) begin
      step();
      if (bus4.seq_done) begin
        if (nd < 20) dt[nd] = t;
        nd++;
        check_eq($sformatf("t6.cnt%0d", nd), 32'(bus4.seq_count), 32'(nd % 16));
        if (nd == 8)  chg = t + 1;
        if (nd == 15) bus4.cont = 1'b0;
      end
      if (t == chg) bus4.period = 4'd3;
    end
    check_eq("t6.ndone", 32'(nd), 32'd16);
    check_eq("t6.first", 32'(dt[0]), 32'd4);
    for (int i = 1; i < 16; i++) begin
      check_eq($sformatf("t6.gap%0d", i), 32'(dt[i] - dt[i-1]), (i >= 9) ? 32'd6 : 32'd4);
    end
    check_eq("t6.busy", 32'(bus4.busy), 32'd0);
    check_eq("t6.wrap", 32'(bus4.seq_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
